mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port synchronous block RAM between two requesters.
- Port 0 is the cpu_core bus adapter; port 1 is the debug/loader DMA.
- Each requester uses a req/ack handshake; the arbiter sequences each RAM access through a fixed 4-cycle FSM.
- Tie-break is round-robin by default; fixed CPU priority is available as a compile option.

Parameters:
- ADDR_WIDTH, 16, RAM address width (6502 address space).
- DATA_WIDTH, 8, RAM data width.

Ports:
- i_Clk  in  1  system clock (12 MHz board clock).
- i_Reset  in  1  synchronous, active-high reset.
- i_Req0  in  1  port 0 request; held high until o_Ack0.
- i_We0  in  1  port 0 write enable (1 = write, 0 = read).
- i_Addr0  in  ADDR_WIDTH  port 0 address.
- i_Wdata0  in  DATA_WIDTH  port 0 write data.
- o_Ack0  out  1  port 0 completion pulse (1 cycle).
- i_Req1, i_We1, i_Addr1, i_Wdata1, o_Ack1: same as port 0, for port 1.
- o_Rdata  out  DATA_WIDTH  read data; valid in the ack cycle of a read.
- o_Mem_En  out  1  RAM enable.
- o_Mem_We  out  1  RAM write enable.
- o_Mem_Addr  out  ADDR_WIDTH  RAM address.
- o_Mem_Wdata  out  DATA_WIDTH  RAM write data.
- i_Mem_Rdata  in  DATA_WIDTH  RAM read data; 1-cycle latency after the enable edge.
- o_Busy  out  1  high in any state other than IDLE.
- o_Grant  out  1  port currently owning the bus (0 or 1).

Behaviour:
- Reset values: all outputs 0. State = IDLE. last_grant = 1, so port 0 wins the first tie.
- Requester protocol: req, we, addr and wdata must be stable from req rising until the ack cycle. The requester drops req in the ack cycle or the cycle after.
- FSM states: IDLE -> ISSUE -> CAPT -> ACK -> IDLE.
- IDLE:
  - Only req0 high: select port 0. Only req1 high: select port 1.
  - Both high: select !last_grant.
  - On selection, at the next edge register o_Mem_En=1, o_Mem_We, o_Mem_Addr, o_Mem_Wdata from the winner; set o_Grant and last_grant; go to ISSUE.
  - No req: stay in IDLE with o_Mem_En=0.
- ISSUE: the RAM samples the enable at this edge. At the edge, clear o_Mem_En/o_Mem_We and go to CAPT.
- CAPT:
  - Read: i_Mem_Rdata is valid; register it into o_Rdata at the edge.
  - Write: o_Rdata keeps its previous value.
  - Assert the granted port's ack at the edge; go to ACK.
- ACK: exactly one o_AckN high for one cycle; go to IDLE at the edge, clearing ack.
  - The requester's req is ignored during ACK.
  - In the IDLE cycle after ACK, the just-acked port's req is masked if still high (one-cycle grace). This prevents a double access.
- Latency: req seen high in IDLE at cycle 0 gives ack high in cycle 3. Back-to-back throughput is one access per 4 cycles.
- o_Mem_* change only at IDLE->ISSUE and ISSUE->CAPT. The RAM sees exactly one enable cycle per access.
- Req dropped mid-access is a protocol violation. The access still completes and ack still pulses.
- Never both acks in the same cycle. o_Grant is stable from ISSUE through ACK.
- Reset mid-access:
  - FSM returns to IDLE and all outputs clear; no ack is issued for the aborted access.
  - A write whose ISSUE edge coincides with the reset edge may still commit in RAM. Software must not rely on it either way.
- Address/data: no arithmetic; ADDR_WIDTH and DATA_WIDTH are passed through unchanged.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a tie in IDLE; last_grant is ignored. Port 1 is served only when req0 is low or masked by the ACK grace cycle.
- Undefined: round-robin tie-break as described in Behaviour.

Test Plan:
- Single read: RAM[0x1234]=0xA5; req0 read addr 0x1234 at cycle 0 -> o_Mem_En high cycle 1 only with addr 0x1234; o_Ack0 high cycle 3; o_Rdata=0xA5 in cycle 3.
- Single write: req1 write 0x0200<=0x3C -> o_Mem_En=o_Mem_We=1 for exactly one cycle; o_Ack1 in cycle 3; a subsequent req0 read of 0x0200 returns 0x3C.
- Contention, round-robin: req0 and req1 held high continuously -> grant order 0,1,0,1; acks every 4 cycles; never simultaneous. With ARB_FIXED_PRIO_EN: order 0,1,0,1 only because of the grace mask; with req0 re-raised after the grace cycle, port 0 wins every tie.
- Held req after ack: req0 held 2 cycles past o_Ack0 -> exactly one access is performed, not two.
- Reset in ISSUE: assert i_Reset in the ISSUE cycle of a port 0 read -> next cycle all outputs 0, o_Busy=0, no o_Ack0; a new req0 completes normally with 3-cycle latency.
- Idle: no requests for 20 cycles -> o_Mem_En=0, o_Busy=0, acks low throughout.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port req/ack arbiter sharing one single-port synchronous RAM via a fixed 4-cycle access sequence.
// Define ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
//
// state  | meaning
// IDLE   | waiting for a request; selects the winner and drives the RAM enable
// ISSUE  | RAM samples the enable at the end of this cycle
// CAPT   | RAM read data valid; captured for reads, ack raised
// ACK    | one-cycle ack pulse to the granted port
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Req0,
    input  logic                  i_We0,
    input  logic [ADDR_WIDTH-1:0] i_Addr0,
    input  logic [DATA_WIDTH-1:0] i_Wdata0,
    output logic                  o_Ack0,
    input  logic                  i_Req1,
    input  logic                  i_We1,
    input  logic [ADDR_WIDTH-1:0] i_Addr1,
    input  logic [DATA_WIDTH-1:0] i_Wdata1,
    output logic                  o_Ack1,
    output logic [DATA_WIDTH-1:0] o_Rdata,
    output logic                  o_Mem_En,
    output logic                  o_Mem_We,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
    input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
    output logic                  o_Busy,
    output logic                  o_Grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grace_q, grace_d;
    logic                  grant_q, grant_d;
    logic                  op_we_q, op_we_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  busy_q, busy_d;
    logic                  req0_v, req1_v, sel;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grace_d      = 1'b0;
        grant_d      = grant_q;
        op_we_d      = op_we_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        ack0_d       = ack0_q;
        ack1_d       = ack1_q;
        busy_d       = busy_q;

        // the port acked last is ignored for one IDLE cycle so a slow req drop cannot re-trigger it
        req0_v = i_Req0 && !(grace_q && !last_grant_q);
        req1_v = i_Req1 && !(grace_q && last_grant_q);
`ifdef ARB_FIXED_PRIO_EN
        sel = !req0_v;
`else
        sel = (req0_v && req1_v) ? !last_grant_q : req1_v;
`endif

        case (state_q)
            S_IDLE: begin
                if (req0_v || req1_v) begin
                    mem_en_d     = 1'b1;
                    mem_we_d     = sel ? i_We1 : i_We0;
                    op_we_d      = sel ? i_We1 : i_We0;
                    mem_addr_d   = sel ? i_Addr1 : i_Addr0;
                    mem_wdata_d  = sel ? i_Wdata1 : i_Wdata0;
                    grant_d      = sel;
                    last_grant_d = sel;
                    busy_d       = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = S_CAPT;
            end
            S_CAPT: begin
                if (!op_we_q) rdata_d = i_Mem_Rdata;
                ack0_d  = !grant_q;
                ack1_d  = grant_q;
                state_d = S_ACK;
            end
            S_ACK: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                busy_d  = 1'b0;
                grace_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grace_q      <= 1'b0;
            grant_q      <= 1'b0;
            op_we_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grace_q      <= grace_d;
            grant_q      <= grant_d;
            op_we_q      <= op_we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign o_Ack0      = ack0_q;
    assign o_Ack1      = ack1_q;
    assign o_Rdata     = rdata_q;
    assign o_Mem_En    = mem_en_q;
    assign o_Mem_We    = mem_we_q;
    assign o_Mem_Addr  = mem_addr_q;
    assign o_Mem_Wdata = mem_wdata_q;
    assign o_Busy      = busy_q;
    assign o_Grant     = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter with a transaction-level timing/arbitration model and a RAM model.
module tb_mem_bus_arbiter;
    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Req0 = 1'b0, i_We0 = 1'b0, i_Req1 = 1'b0, i_We1 = 1'b0;
    logic [15:0] i_Addr0 = '0, i_Addr1 = '0;
    logic [7:0]  i_Wdata0 = '0, i_Wdata1 = '0;
    logic        o_Ack0, o_Ack1, o_Mem_En, o_Mem_We, o_Busy, o_Grant;
    logic [7:0]  o_Rdata, o_Mem_Wdata;
    logic [7:0]  i_Mem_Rdata = '0;
    logic [15:0] o_Mem_Addr;

    always #5 i_Clk = ~i_Clk;

    mem_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_Req0(i_Req0), .i_We0(i_We0), .i_Addr0(i_Addr0), .i_Wdata0(i_Wdata0), .o_Ack0(o_Ack0),
        .i_Req1(i_Req1), .i_We1(i_We1), .i_Addr1(i_Addr1), .i_Wdata1(i_Wdata1), .o_Ack1(o_Ack1),
        .o_Rdata(o_Rdata), .o_Mem_En(o_Mem_En), .o_Mem_We(o_Mem_We), .o_Mem_Addr(o_Mem_Addr),
        .o_Mem_Wdata(o_Mem_Wdata), .i_Mem_Rdata(i_Mem_Rdata), .o_Busy(o_Busy), .o_Grant(o_Grant)
    );

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // behavioural single-port RAM, one-cycle read latency
    logic [7:0] ram [int];
    always @(posedge i_Clk) begin
        if (o_Mem_En) begin
            if (o_Mem_We) ram[int'(o_Mem_Addr)] = o_Mem_Wdata;
            else i_Mem_Rdata <= ram.exists(int'(o_Mem_Addr)) ? ram[int'(o_Mem_Addr)] : dflt(o_Mem_Addr);
        end
    end

    logic [7:0] shadow [int];
    function automatic logic [7:0] shadow_rd(input logic [15:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : dflt(a);
    endfunction

    int n_cmp = 0, n_err = 0, n = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, n, got, exp);
        end
    endtask

    // requesters
    bit          p_req [2];
    bit          p_we [2];
    logic [15:0] p_addr [2];
    logic [7:0]  p_wdata [2];
    int          p_hold [2];
    int          p_dn [2] = '{-1, -1};
    bit          p_auto [2];
    bit          rand_mode = 1'b0;
    int          rst_at = -1;
    int          en_cnt = 0;

    // model: one access selected at cycle sel_c occupies sel_c+1 .. sel_c+3, ack at sel_c+3
    int          sel_c = -1, busy_until = 0, grace_c = -1;
    bit          owner, grace_p, last = 1'b1, sel_we, exp_grant = 1'b0;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata, sel_rdata, exp_rdata = '0;

    task automatic post(input int k, input bit we, input logic [15:0] a, input logic [7:0] d, input int hold);
        p_req[k] = 1'b1; p_we[k] = we; p_addr[k] = a; p_wdata[k] = d; p_hold[k] = hold; p_dn[k] = -1;
    endtask

    task automatic cycle();
        bit rst, e0, e1, w, ackk, act, iss, ackc;
        for (int k = 0; k < 2; k++) begin
            ackk = (k == 1) ? o_Ack1 : o_Ack0;
            if (p_dn[k] >= 0) begin
                if (p_dn[k] == 0) begin p_req[k] = 1'b0; p_dn[k] = -1; end
                else p_dn[k]--;
            end else if (p_req[k] && ackk) begin
                if (p_hold[k] == 0) p_req[k] = 1'b0;
                else p_dn[k] = p_hold[k];
            end else if (!p_req[k] && (p_auto[k] || (rand_mode && $urandom_range(0, 3) == 0))) begin
                post(k, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                     rand_mode ? int'($urandom_range(0, 1)) : 0);
            end
        end
        rst = (n == rst_at) || (rand_mode && $urandom_range(0, 199) == 0);
        i_Reset = rst;
        i_Req0 = p_req[0]; i_We0 = p_we[0]; i_Addr0 = p_addr[0]; i_Wdata0 = p_wdata[0];
        i_Req1 = p_req[1]; i_We1 = p_we[1]; i_Addr1 = p_addr[1]; i_Wdata1 = p_wdata[1];

        if (rst) begin
            sel_c = -1; busy_until = n + 1; grace_c = -1; last = 1'b1; exp_grant = 1'b0; exp_rdata = '0;
        end else if (n >= busy_until) begin
            e0 = p_req[0] && !(n == grace_c && grace_p == 1'b0);
            e1 = p_req[1] && !(n == grace_c && grace_p == 1'b1);
            if (e0 || e1) begin
`ifdef ARB_FIXED_PRIO_EN
                w = e0 ? 1'b0 : 1'b1;
`else
                if (e0 && e1) w = ~last;
                else w = e1;
`endif
                sel_c = n; owner = w; last = w; exp_grant = w;
                busy_until = n + 4; grace_c = n + 4; grace_p = w;
                sel_we = p_we[w]; sel_addr = p_addr[w]; sel_wdata = p_wdata[w];
                if (sel_we) shadow[int'(sel_addr)] = sel_wdata;
                else sel_rdata = shadow_rd(sel_addr);
            end
        end

        @(negedge i_Clk);
        n++;
        if (o_Mem_En) en_cnt++;
        act  = sel_c >= 0 && n > sel_c && n <= sel_c + 3;
        iss  = sel_c >= 0 && n == sel_c + 1;
        ackc = sel_c >= 0 && n == sel_c + 3;
        check_eq("busy", 32'(o_Busy), 32'(act));
        check_eq("mem_en", 32'(o_Mem_En), 32'(iss));
        check_eq("mem_we", 32'(o_Mem_We), 32'(iss && sel_we));
        if (iss) begin
            check_eq("mem_addr", 32'(o_Mem_Addr), 32'(sel_addr));
            if (sel_we) check_eq("mem_wdata", 32'(o_Mem_Wdata), 32'(sel_wdata));
        end
        check_eq("ack0", 32'(o_Ack0), 32'(ackc && owner == 1'b0));
        check_eq("ack1", 32'(o_Ack1), 32'(ackc && owner == 1'b1));
        if (ackc && !sel_we) exp_rdata = sel_rdata;
        check_eq("rdata", 32'(o_Rdata), 32'(exp_rdata));
        check_eq("grant", 32'(o_Grant), 32'(exp_grant));
    endtask

    task automatic run(input int cnt);
        for (int i = 0; i < cnt; i++) cycle();
    endtask

    initial begin
        int e0;
        @(negedge i_Clk);
        check_eq("rst_ack0", 32'(o_Ack0), 0);
        check_eq("rst_ack1", 32'(o_Ack1), 0);
        check_eq("rst_busy", 32'(o_Busy), 0);
        check_eq("rst_mem_en", 32'(o_Mem_En), 0);
        check_eq("rst_grant", 32'(o_Grant), 0);
        check_eq("rst_rdata", 32'(o_Rdata), 0);
        check_eq("rst_mem_addr", 32'(o_Mem_Addr), 0);

        run(20);                                        // idle
        post(1, 1'b1, 16'h1234, 8'hA5, 0); run(6);      // load RAM[0x1234] = 0xA5
        post(0, 1'b0, 16'h1234, 8'h00, 0); run(5);
        check_eq("read_1234", 32'(o_Rdata), 32'h0000_00A5);
        post(1, 1'b1, 16'h0200, 8'h3C, 0); run(6);
        post(0, 1'b0, 16'h0200, 8'h00, 0); run(6);
        check_eq("read_0200", 32'(o_Rdata), 32'h0000_003C);

        e0 = en_cnt;
        post(0, 1'b0, 16'h0200, 8'h00, 1); run(10);     // req held past ack
        check_eq("held_one_access", en_cnt - e0, 1);

        post(0, 1'b0, 16'h1234, 8'h00, 0); rst_at = n + 1; run(3);  // reset in ISSUE
        check_eq("abort_no_ack0", 32'(o_Ack0), 0);
        run(6);
        check_eq("reissue_read", 32'(o_Rdata), 32'h0000_00A5);

        e0 = en_cnt;
        p_auto[0] = 1'b1; p_auto[1] = 1'b1;              // contention
        post(0, 1'b0, 16'h0001, 8'h00, 0); post(1, 1'b1, 16'h0002, 8'h11, 0);
        run(32);
        check_eq("contention_rate", en_cnt - e0, 8);
        p_auto[0] = 1'b0; p_auto[1] = 1'b0;
        run(10);

        rand_mode = 1'b1; run(4000);
        rand_mode = 1'b0; run(12);
        check_eq("drain_req0", 32'(p_req[0]), 0);
        check_eq("drain_req1", 32'(p_req[1]), 0);
        check_eq("drain_busy", 32'(o_Busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
